// File: rtl/fixed_arith_pkg.sv
// Shared fixed-point helpers: signed saturation bounds and rounding-mode encoding.
package fixed_arith_pkg;

   // Only ROUND_HALF_UP is implemented; ROUND_HALF_EVEN is reserved.
   typedef enum logic [0:0] {
      ROUND_HALF_UP   = 1'b0,
      ROUND_HALF_EVEN = 1'b1
   } round_mode_e;

   function automatic logic signed [63:0] sat_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/fixed_acc_requantize_if.sv
// Valid/ready stream bundle used for both the wide input and the narrow output side.
interface fixed_acc_requantize_if #(
   parameter int W = 16
);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fixed_round_shift_sat.sv
// Combinational arithmetic shift of a pre-rounded value followed by signed saturation.
module fixed_round_shift_sat
   import fixed_arith_pkg::*;
#(
   parameter int RW        = 35,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT     = 8
) (
   input  logic signed [RW-1:0]        r,
   output logic signed [OUT_WIDTH-1:0] val,
   output logic                        sat
);

   // When the shifted value always fits, no clamp logic is generated.
   localparam bit NO_SAT = (OUT_WIDTH >= RW - SHIFT);

   generate
      if (NO_SAT) begin : g_nosat
         assign val = OUT_WIDTH'(r >>> SHIFT);
         assign sat = 1'b0;
      end else begin : g_clamp
         localparam logic signed [63:0]          HI64   = sat_max(OUT_WIDTH);
         localparam logic signed [63:0]          LO64   = sat_min(OUT_WIDTH);
         localparam logic signed [RW-1:0]        HI_R   = HI64[RW-1:0];
         localparam logic signed [RW-1:0]        LO_R   = LO64[RW-1:0];
         localparam logic signed [OUT_WIDTH-1:0] HI_OUT = HI64[OUT_WIDTH-1:0];
         localparam logic signed [OUT_WIDTH-1:0] LO_OUT = LO64[OUT_WIDTH-1:0];

         logic signed [RW-1:0] q;
         assign q = r >>> SHIFT;

         always_comb begin
            val = q[OUT_WIDTH-1:0];
            sat = 1'b0;
            if (q > HI_R) begin
               val = HI_OUT;
               sat = 1'b1;
            end else if (q < LO_R) begin
               val = LO_OUT;
               sat = 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/fixed_acc_requantize.sv
// Two-stage requantizer: round-half-up shift, saturate, sticky saturation-event counter.
module fixed_acc_requantize
   import fixed_arith_pkg::*;
#(
   parameter int IN_WIDTH      = 34,
   parameter int OUT_WIDTH     = 16,
   parameter int SHIFT         = 8,
   parameter int SAT_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   fixed_acc_requantize_if.slave    in_if,
   fixed_acc_requantize_if.master   out_if,
   output logic [SAT_CNT_WIDTH-1:0] sat_count,
   input  logic                     sat_count_clear
);

   // One guard bit so the rounding add can never overflow.
   localparam int          RW         = IN_WIDTH + 1;
   localparam round_mode_e ROUND_MODE = ROUND_HALF_UP;
   localparam logic [RW-1:0] ONE_R    = RW'(1);
   localparam logic [RW-1:0] RND      =
      (ROUND_MODE == ROUND_HALF_UP && SHIFT > 0) ? (ONE_R << (SHIFT - 1)) : '0;

   logic                     s1_valid_q, s1_valid_d;
   logic signed [RW-1:0]     s1_r_q, s1_r_d;
   logic                     out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]     out_data_q, out_data_d;
   logic [SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

   logic                        s2_advance;
   logic                        in_ready;
   logic                        accept;
   logic                        sat_event;
   logic signed [OUT_WIDTH-1:0] sat_val;
   logic                        sat_flag;

   fixed_round_shift_sat #(
      .RW        (RW),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT     (SHIFT)
   ) u_round_shift_sat (
      .r   (s1_r_q),
      .val (sat_val),
      .sat (sat_flag)
   );

   always_comb begin
      s2_advance  = !out_valid_q || out_if.ready;
      in_ready    = !s1_valid_q || s2_advance;
      accept      = in_if.valid && in_ready;
      sat_event   = s2_advance && s1_valid_q && sat_flag;

      s1_valid_d  = s1_valid_q;
      s1_r_d      = s1_r_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      sat_count_d = sat_count_q;

      if (in_ready) begin
         s1_valid_d = accept;
         if (accept) begin
            s1_r_d = {in_if.data[IN_WIDTH-1], in_if.data} + RND;
         end
      end

      if (s2_advance) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = sat_val;
         end
      end

      // A clear coinciding with a saturated load still records that event.
      if (sat_count_clear) begin
         sat_count_d = sat_event ? SAT_CNT_WIDTH'(1) : '0;
      end else if (sat_event && (sat_count_q != '1)) begin
         sat_count_d = sat_count_q + SAT_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_r_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_r_q      <= s1_r_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign in_if.ready  = in_ready;
   assign out_if.valid = out_valid_q;
   assign out_if.data  = out_data_q;
   assign sat_count    = sat_count_q;

endmodule

// File: tb/tb_fixed_acc_requantize.sv
// Directed bench for fixed_acc_requantize with default parameters.
module tb_fixed_acc_requantize;

   logic        clk;
   logic        rst;
   logic [15:0] sat_count;
   logic        sat_count_clear;

   fixed_acc_requantize_if #(.W(34)) in_if ();
   fixed_acc_requantize_if #(.W(16)) out_if ();

   fixed_acc_requantize #(
      .IN_WIDTH      (34),
      .OUT_WIDTH     (16),
      .SHIFT         (8),
      .SAT_CNT_WIDTH (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .in_if           (in_if),
      .out_if          (out_if),
      .sat_count       (sat_count),
      .sat_count_clear (sat_count_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   longint vin[$];
   longint vexp[$];
   longint vsat[$];

   int          sent, got, occ, cyc;
   logic        acc, emit, hold;
   logic [15:0] prev_data;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Back-to-back burst with ready high; beat j must appear after the edge following its accept.
   task automatic burst(input string tag, input bit check_sat);
      int n;
      n = vin.size();
      for (int i = 0; i <= n + 1; i++) begin
         in_if.valid = (i < n);
         in_if.data  = (i < n) ? vin[i][33:0] : 34'd0;
         #1;
         chk({tag, "_in_ready"}, in_if.ready, 1);
         tick();
         if (i == 0 || i == n + 1) begin
            chk({tag, "_idle_valid"}, out_if.valid, 0);
         end else begin
            chk({tag, "_valid"}, out_if.valid, 1);
            chk({tag, "_data"}, $signed(out_if.data), vexp[i-1]);
            if (check_sat) chk({tag, "_sat_count"}, sat_count, vsat[i-1]);
         end
      end
      in_if.valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      in_if.valid     = 1'b0;
      in_if.data      = '0;
      out_if.ready    = 1'b1;
      sat_count_clear = 1'b0;
      #2;
      chk("rst_out_valid", out_if.valid, 0);
      chk("rst_out_data", $signed(out_if.data), 0);
      chk("rst_sat_count", sat_count, 0);
      #20;
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", in_if.ready, 1);

      // Rounding cases, full throughput.
      vin  = '{384, -384, 128, -128, 127};
      vexp = '{2, -1, 1, 0, 0};
      burst("t1", 1'b0);

      // Saturation and its counter.
      vin  = '{64'sd1073741824, -64'sd1073741824, 8388352, 8388480};
      vexp = '{32767, -32768, 32767, 32767};
      vsat = '{1, 2, 2, 3};
      burst("t2", 1'b1);

      // Random backpressure, occupancy model drives the expected ready.
      sent = 0; got = 0; occ = 0; cyc = 0;
      while (got < 10 && cyc < 300) begin
         out_if.ready = 1'($urandom_range(0, 1));
         in_if.valid  = (sent < 10);
         in_if.data   = 34'(sent << 8);
         #1;
         chk("t3_in_ready", in_if.ready, !(occ == 2 && !out_if.ready));
         acc       = in_if.valid && in_if.ready;
         emit      = out_if.valid && out_if.ready;
         hold      = out_if.valid && !out_if.ready;
         prev_data = out_if.data;
         if (emit) begin
            chk("t3_data", $signed(out_if.data), got);
            got++;
         end
         tick();
         if (hold) begin
            chk("t3_hold_valid", out_if.valid, 1);
            chk("t3_hold_data", out_if.data, prev_data);
         end
         occ = occ + int'(acc) - int'(emit);
         if (acc) sent++;
         cyc++;
      end
      chk("t3_received", got, 10);
      in_if.valid  = 1'b0;
      out_if.ready = 1'b1;
      tick();
      tick();
      chk("t3_drained", out_if.valid, 0);

      // Two beats fill the pipe under stall; the third is taken the cycle ready returns.
      out_if.ready = 1'b0;
      in_if.valid  = 1'b1;
      in_if.data   = 34'd256;
      #1; chk("t4_ready_a", in_if.ready, 1);
      tick(); chk("t4_valid_a", out_if.valid, 0);
      in_if.data = 34'd512;
      #1; chk("t4_ready_b", in_if.ready, 1);
      tick(); chk("t4_data_a", $signed(out_if.data), 1);
      in_if.data = 34'd768;
      #1; chk("t4_ready_c_blocked", in_if.ready, 0);
      tick();
      chk("t4_hold_valid", out_if.valid, 1);
      chk("t4_hold_data", $signed(out_if.data), 1);
      chk("t4_still_blocked", in_if.ready, 0);
      out_if.ready = 1'b1;
      #1; chk("t4_ready_c", in_if.ready, 1);
      tick(); chk("t4_data_b", $signed(out_if.data), 2);
      in_if.valid = 1'b0;
      tick();
      chk("t4_data_c", $signed(out_if.data), 3);
      chk("t4_valid_c", out_if.valid, 1);
      tick(); chk("t4_empty", out_if.valid, 0);

      // Clear, then clear colliding with a saturated load.
      sat_count_clear = 1'b1;
      tick();
      sat_count_clear = 1'b0;
      chk("t5_clear", sat_count, 0);
      in_if.valid = 1'b1;
      in_if.data  = 34'd1073741824;
      for (int i = 0; i < 5; i++) tick();
      in_if.valid = 1'b0;
      tick(); tick();
      chk("t5_count5", sat_count, 5);
      in_if.valid = 1'b1;
      tick();
      in_if.valid     = 1'b0;
      sat_count_clear = 1'b1;
      tick();
      sat_count_clear = 1'b0;
      chk("t5_clear_collide", sat_count, 1);
      tick();
      in_if.valid = 1'b1;
      for (int i = 0; i < 65539; i++) tick();
      in_if.valid = 1'b0;
      tick(); tick();
      chk("t5_no_wrap", sat_count, 65535);
      chk("t5_last_data", $signed(out_if.data), 32767);

      // Async reset with two beats in flight.
      in_if.valid = 1'b1;
      in_if.data  = 34'd256;
      tick();
      in_if.data  = 34'd512;
      tick();
      in_if.valid = 1'b0;
      chk("t6_pre_valid", out_if.valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", out_if.valid, 0);
      chk("t6_rst_sat", sat_count, 0);
      chk("t6_rst_data", $signed(out_if.data), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      tick();
      chk("t6_in_ready", in_if.ready, 1);
      for (int i = 0; i < 3; i++) begin
         chk("t6_no_stale", out_if.valid, 0);
         tick();
      end
      in_if.valid = 1'b1;
      in_if.data  = 34'd256;
      tick();
      in_if.valid = 1'b0;
      chk("t6_latency_gap", out_if.valid, 0);
      tick();
      chk("t6_new_valid", out_if.valid, 1);
      chk("t6_new_data", $signed(out_if.data), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
